// File: rtl/seq_factorial_pkg.sv
// Shared definitions for the iterative factorial engine: FSM encoding,
// default widths and a 64-bit reference factorial for scoreboards.
package fact_pkg;

   localparam int IN_W_DEF  = 4;
   localparam int OUT_W_DEF = 44;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIN  = 2'd2
   } state_t;

   // Exact for n <= 20; anything larger silently wraps at 64 bits.
   function automatic logic [63:0] fact_ref(input int unsigned n);
      logic [63:0] r;
      r = 64'd1;
      for (int unsigned i = 2; i <= n; i++) begin
         r = r * 64'(i);
      end
      return r;
   endfunction

endpackage

// File: rtl/seq_factorial_if.sv
// Start/busy/done handshake bundle between a requester and seq_factorial.
interface seq_factorial_if
   import fact_pkg::*;
#(
   parameter int IN_W  = IN_W_DEF,
   parameter int OUT_W = OUT_W_DEF
);

   logic             start;
   logic [IN_W-1:0]  in;
   logic             busy;
   logic             done;
   logic [OUT_W-1:0] facto;
   logic             overflow;

   modport master (output start, in, input busy, done, facto, overflow);
   modport slave  (input start, in, output busy, done, facto, overflow);

endinterface

// File: rtl/seq_factorial_mul_step.sv
// One multiply step: acc*cnt at full width, with detection of bits above OUT_W.
module fact_mul_step #(
   parameter int IN_W  = 4,
   parameter int OUT_W = 44
) (
   input  logic [OUT_W-1:0] acc,
   input  logic [IN_W-1:0]  cnt,
   output logic [OUT_W-1:0] prod_lo,
   output logic             hi_nz
);

   logic [OUT_W+IN_W-1:0] prod;

   assign prod    = {{IN_W{1'b0}}, acc} * {{OUT_W{1'b0}}, cnt};
   assign prod_lo = prod[OUT_W-1:0];
   assign hi_nz   = |prod[OUT_W+IN_W-1:OUT_W];

endmodule

// File: rtl/seq_factorial.sv
// Iterative factorial engine: one multiply per clock, saturating result with
// a sticky overflow flag so latency depends only on n.
module seq_factorial
   import fact_pkg::*;
#(
   parameter int IN_W  = IN_W_DEF,
   parameter int OUT_W = OUT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   seq_factorial_if.slave   bus
);

   state_t           state;
   logic [OUT_W-1:0] acc;
   logic [IN_W-1:0]  cnt;
   logic             ovf;
   logic [OUT_W-1:0] prod_lo;
   logic             hi_nz;

   fact_mul_step #(.IN_W(IN_W), .OUT_W(OUT_W)) u_mul (
      .acc     (acc),
      .cnt     (cnt),
      .prod_lo (prod_lo),
      .hi_nz   (hi_nz)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= S_IDLE;
         acc          <= '0;
         cnt          <= '0;
         ovf          <= 1'b0;
         bus.busy     <= 1'b0;
         bus.done     <= 1'b0;
         bus.facto    <= '0;
         bus.overflow <= 1'b0;
      end else begin
         bus.done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  cnt      <= bus.in;
                  acc      <= OUT_W'(1);
                  ovf      <= 1'b0;
                  bus.busy <= 1'b1;
                  state    <= S_CALC;
               end
            end
            S_CALC: begin
               if (cnt <= IN_W'(1)) begin
                  state <= S_FIN;
               end else begin
                  // Keep multiplying after overflow so done timing never shifts.
                  if (hi_nz || ovf) begin
                     ovf <= 1'b1;
                  end
                  acc <= prod_lo;
                  cnt <= cnt - IN_W'(1);
               end
            end
            S_FIN: begin
               bus.facto    <= ovf ? {OUT_W{1'b1}} : acc;
               bus.overflow <= ovf;
               bus.done     <= 1'b1;
               bus.busy     <= 1'b0;
               state        <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
